// File: rtl/mem_unit_pkg.sv
// mem_unit_pkg
//   Shared definitions for the memory access unit: command encodings issued by
//   the control unit, FSM state encodings, and a small command classifier.
//   No ports (package).
package mem_unit_pkg;

  // Command encodings on the 3-bit cmd bus
  localparam logic [2:0] CMD_NOP   = 3'd0;
  localparam logic [2:0] CMD_FETCH = 3'd1;
  localparam logic [2:0] CMD_LOAD  = 3'd2;
  localparam logic [2:0] CMD_STORE = 3'd3;
  localparam logic [2:0] CMD_PUSH  = 3'd4;
  localparam logic [2:0] CMD_POP   = 3'd5;
  localparam logic [2:0] CMD_JUMP  = 3'd6;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // True for commands whose memory access is a write
  function automatic logic is_write_cmd(input logic [2:0] c);
    return (c == CMD_STORE) || (c == CMD_PUSH);
  endfunction

endpackage

// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Executes FETCH/LOAD/STORE/PUSH/POP/JUMP commands from the control unit,
//   drives a request/acknowledge memory port with arbitrary wait states and
//   owns the architectural PC, SP, IR and MDR registers.
//
//   Ports
//     clk, reset            rising-edge clock, synchronous active-high reset
//     cmd_valid/cmd_ready   command handshake (accepted when both high)
//     cmd, cmd_addr,        command code, LOAD/STORE address or JUMP target,
//     cmd_wdata             STORE/PUSH write data
//     mem_req, mem_we,      memory request (held until mem_ack), write enable,
//     mem_addr, mem_wdata   address (MAR) and write data (MDR)
//     mem_rdata, mem_ack    read data and single-cycle acknowledge
//     done, err             completion pulse; err pulses with done on abort
//     pc, sp, ir, mdr       architectural registers
//
//   Optional feature: define MEM_TIMEOUT_EN to abort a request that has not
//   been acknowledged within TIMEOUT cycles (done=err=1, registers restored).
//   Without it the request waits indefinitely.
module mem_access_unit
  import mem_unit_pkg::*;
#(
  parameter int                DATA_W      = 16,
  parameter int                ADDR_W      = 16,
  parameter logic [ADDR_W-1:0] PC_RESET    = '0,
  parameter logic [ADDR_W-1:0] SP_INIT     = 'hFFFF,
  parameter logic [ADDR_W-1:0] STACK_LIMIT = 'hFF00,
  parameter int                TIMEOUT     = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] sp,
  output logic [DATA_W-1:0] ir,
  output logic [DATA_W-1:0] mdr
);

  logic [1:0]        state_reg;
  logic [2:0]        op_reg;      // command currently in flight
  logic [ADDR_W-1:0] pc_reg;
  logic [ADDR_W-1:0] sp_reg;
  logic [ADDR_W-1:0] mar_reg;
  logic [DATA_W-1:0] ir_reg;
  logic [DATA_W-1:0] mdr_reg;
  logic              we_reg;
  logic              err_reg;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0]  cnt_reg;
  // Pre-command copies so an aborted request leaves no trace
  logic [ADDR_W-1:0] sp_save_reg;
  logic [DATA_W-1:0] mdr_save_reg;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      op_reg    <= CMD_NOP;
      pc_reg    <= PC_RESET;
      sp_reg    <= SP_INIT;
      mar_reg   <= '0;
      ir_reg    <= '0;
      mdr_reg   <= '0;
      we_reg    <= 1'b0;
      err_reg   <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt_reg      <= '0;
      sp_save_reg  <= SP_INIT;
      mdr_save_reg <= '0;
`endif
    end else begin
      // err is only ever high during the single DONE cycle
      err_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_reg <= cmd;
            we_reg <= is_write_cmd(cmd);
`ifdef MEM_TIMEOUT_EN
            cnt_reg      <= '0;
            sp_save_reg  <= sp_reg;
            mdr_save_reg <= mdr_reg;
`endif
            case (cmd)
              CMD_FETCH: begin
                mar_reg   <= pc_reg;
                state_reg <= ST_REQ;
              end
              CMD_LOAD: begin
                mar_reg   <= cmd_addr;
                state_reg <= ST_REQ;
              end
              CMD_STORE: begin
                mar_reg   <= cmd_addr;
                mdr_reg   <= cmd_wdata;
                state_reg <= ST_REQ;
              end
              CMD_PUSH: begin
                if (sp_reg == STACK_LIMIT) begin
                  // Overflow: no access, SP untouched
                  we_reg    <= 1'b0;
                  err_reg   <= 1'b1;
                  state_reg <= ST_DONE;
                end else begin
                  // Full-descending stack: pre-decrement, write at new SP
                  sp_reg    <= sp_reg - ADDR_W'(1);
                  mar_reg   <= sp_reg - ADDR_W'(1);
                  mdr_reg   <= cmd_wdata;
                  state_reg <= ST_REQ;
                end
              end
              CMD_POP: begin
                if (sp_reg == SP_INIT) begin
                  // Underflow: stack empty
                  err_reg   <= 1'b1;
                  state_reg <= ST_DONE;
                end else begin
                  mar_reg   <= sp_reg;
                  state_reg <= ST_REQ;
                end
              end
              CMD_JUMP: begin
                pc_reg    <= cmd_addr;
                state_reg <= ST_DONE;
              end
              default: begin
                // NOP and unused encodings complete without memory traffic
                state_reg <= ST_DONE;
              end
            endcase
          end
        end

        ST_REQ: begin
          if (mem_ack) begin
            we_reg    <= 1'b0;
            state_reg <= ST_DONE;
            case (op_reg)
              CMD_FETCH: begin
                ir_reg <= mem_rdata;
                pc_reg <= pc_reg + ADDR_W'(1);
              end
              CMD_LOAD: begin
                mdr_reg <= mem_rdata;
              end
              CMD_POP: begin
                mdr_reg <= mem_rdata;
                sp_reg  <= sp_reg + ADDR_W'(1);
              end
              default: begin
              end
            endcase
          end
`ifdef MEM_TIMEOUT_EN
          else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
            // Abort: this was the last waiting cycle with no ack
            we_reg    <= 1'b0;
            err_reg   <= 1'b1;
            sp_reg    <= sp_save_reg;
            mdr_reg   <= mdr_save_reg;
            state_reg <= ST_DONE;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
`endif
        end

        ST_DONE: begin
          state_reg <= ST_IDLE;
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = (state_reg == ST_IDLE);
  assign mem_req   = (state_reg == ST_REQ);
  assign mem_we    = we_reg;
  assign mem_addr  = mar_reg;
  assign mem_wdata = mdr_reg;
  assign done      = (state_reg == ST_DONE);
  assign err       = err_reg;
  assign pc        = pc_reg;
  assign sp        = sp_reg;
  assign ir        = ir_reg;
  assign mdr       = mdr_reg;

endmodule
